noise_gate: RTL
===============

Name: noise_gate

Overview:
- Second DSP stage of the effects chain (fx slot 1).
- Sits between the input-gain stage and the EQ.
- Tracks a peak envelope of the incoming signed samples and applies a gain-ramped gate. The gate has attack, hold and release phases.
- Threshold, hold and release come from the controller's fx-1 parameter bank (defaults 10 / 40 / 5).

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- PARAM_W, 8: controller parameter width.
- ENV_SHIFT, 4: envelope decay shift; decay = env >> ENV_SHIFT per sample.
- HOLD_UNIT, 64: samples per hold_i step.
- ATTACK_STEP, 4096: gain increment per sample in ATTACK.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle sample strobe; no backpressure, at most one per cycle
- in_data  in  DATA_W  signed input sample
- bypass  in  1  1 = pass input unmodified (FSM keeps running)
- thresh_i  in  PARAM_W  open threshold; level = thresh_i << 7
- hold_i  in  PARAM_W  hold time = hold_i * HOLD_UNIT samples
- release_i  in  PARAM_W  release rate selector
- out_valid  out  1  output sample strobe
- out_data  out  DATA_W  signed gated sample
- gate_open  out  1  1 whenever state != CLOSED

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = CLOSED; gain = 0; env = 0; hold counter = 0.
  - All pipeline valids = 0; out_data = 0; gate_open = 0.
- Pipeline: 3 stages. out_valid is asserted exactly 3 cycles after each in_valid. Cycles without in_valid do not advance any state.
- S1 (envelope):
  - abs = |in_data|, saturating: -32768 maps to 32767.
  - If abs > env, env = abs; otherwise env = env - (env >> ENV_SHIFT). env is 16-bit unsigned.
  - The sample and the updated env are registered.
- S2 (FSM and gain): parameters are sampled on this cycle.
  - open_lvl = thresh_i << 7 (16-bit).
  - close_lvl = open_lvl >> 1 (hysteresis).
  - rel_step = 1024 >> min(release_i, 10), range 1..1024.
  - Gain is 16-bit unsigned; unity = 32768.
  - CLOSED: gain = 0. If env > open_lvl, go to ATTACK.
  - ATTACK: gain = min(gain + ATTACK_STEP, 32768). When the new gain = 32768, go to OPEN.
  - OPEN: gain = 32768. If env <= close_lvl: when hold_i == 0 go directly to RELEASE; otherwise go to HOLD and load counter = hold_i * HOLD_UNIT.
  - HOLD: gain unchanged. If env > open_lvl, go to OPEN (counter is discarded). Otherwise decrement the counter; when it reaches 0, go to RELEASE.
  - RELEASE: if env > open_lvl, go to ATTACK, ramping from the current gain. Otherwise gain = gain - rel_step; if gain <= rel_step, set gain = 0 and go to CLOSED.
  - Transitions and the gain update take effect in the same S2 cycle. The sample carried in S2 uses the post-update gain.
- S3 (apply):
  - out_data = sat16((sample * signed{1'b0, gain}) >>> 15).
  - If bypass = 1, out_data = the registered input sample, with the same 3-cycle latency.
  - A result of -32768 at unity is preserved exactly.
- Boundary cases:
  - thresh_i = 0: any nonzero env opens the gate; an all-zero input keeps it CLOSED.
  - thresh_i = 255: open_lvl = 32640; only |x| > 32640 opens.
  - Parameter change mid-HOLD: the loaded counter is unaffected; the new thresholds apply on the next sample.
  - Reset mid-RELEASE or mid-pipeline: immediate return to reset values; in-flight samples are dropped (no out_valid).

Decomposition:
- Add to lab_pkg:
  - gate_state_t enum {CLOSED, ATTACK, OPEN, HOLD, RELEASE}.
  - GATE_UNITY = 32768, GATE_HOLD_UNIT, GATE_ATTACK_STEP.
  - Reuse sat16.
- One sub-module: gate_env_follower. It contains S1 (abs, peak envelope, valid register).
- The FSM, gain and multiply stay in noise_gate.

Test Plan:
- Reset check: assert rst_n low mid-stream -> out_valid = 0, out_data = 0, gate_open = 0 in the same cycle; state CLOSED after release of reset.
- Open/attack: thresh_i = 10 (open_lvl 1280); feed constant 5000 at one sample per 4 cycles.
  - out_valid follows each strobe by exactly 3 cycles.
  - Outputs ramp 625, 1250, …, 4375 (seven samples), then 5000 thereafter.
  - gate_open rises on the first sample.
- Hold/release: after the open state, feed 0s with hold_i = 1 and release_i = 5.
  - Gate enters HOLD when env <= 640 (cycle count must match a reference model of env decay).
  - Stays at unity for 64 samples.
  - Gain then drops 32 per sample and reaches CLOSED after 1024 samples; gate_open falls.
- Re-trigger: during RELEASE at gain ≈ 16000, feed 5000 -> ATTACK resumes from 16000 and reaches OPEN within 5 samples.
- Saturation: input -32768 with the gate OPEN -> out_data = -32768; envelope = 32767.
- Bypass: bypass = 1 with the gate CLOSED, input 1234 -> out_data = 1234 after 3 cycles; gate_open still follows the FSM.

Source files
------------

// File: rtl/noise_gate_pkg.sv
// Shared types and constants for the noise gate (fx slot 1).
package noise_gate_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

  localparam int GATE_UNITY       = 32768;
  localparam int GATE_HOLD_UNIT   = 64;
  localparam int GATE_ATTACK_STEP = 4096;

  // Clamp a wide signed intermediate into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767) begin
      return 16'sh7fff;
    end else if (x < -33'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/noise_gate_env_follower.sv
// Stage 1 of the gate: saturating magnitude and peak envelope with
// exponential decay. Registers the sample alongside the updated envelope.
module gate_env_follower
  import noise_gate_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ENV_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_data_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] sample_o,
  output logic        [DATA_W-1:0] env_o
);

  logic                     valid_q;
  logic signed [DATA_W-1:0] sample_q;
  logic        [DATA_W-1:0] env_q;
  logic        [DATA_W-1:0] env_d;
  logic        [DATA_W-1:0] abs_w;

  // Magnitude (most-negative code folds to the largest positive code) and envelope update.
  always_comb begin
    abs_w = in_data_i;
    if (in_data_i[DATA_W-1]) begin
      if (in_data_i == {1'b1, {(DATA_W-1){1'b0}}}) begin
        abs_w = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        abs_w = -in_data_i;
      end
    end
    if (abs_w > env_q) begin
      env_d = abs_w;
    end else begin
      env_d = env_q - (env_q >> ENV_SHIFT);
    end
  end

  // Envelope and sample only move on a strobe; the valid bit follows every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
      env_q    <= '0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        sample_q <= in_data_i;
        env_q    <= env_d;
      end
    end
  end

  assign valid_o  = valid_q;
  assign sample_o = sample_q;
  assign env_o    = env_q;

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope follower (S1), gate FSM with gain ramp (S2),
// gain multiply or bypass (S3). Three-cycle latency, no backpressure.
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PARAM_W     = 8,
  parameter int ENV_SHIFT   = 4,
  parameter int HOLD_UNIT   = GATE_HOLD_UNIT,
  parameter int ATTACK_STEP = GATE_ATTACK_STEP
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      bypass,
  input  logic        [PARAM_W-1:0] thresh_i,
  input  logic        [PARAM_W-1:0] hold_i,
  input  logic        [PARAM_W-1:0] release_i,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      gate_open
);

  localparam logic [15:0] UNITY16 = 16'(GATE_UNITY);

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_sample;
  logic        [DATA_W-1:0] s1_env;

  gate_state_t              state_q;
  logic        [15:0]       gain_q;
  logic        [15:0]       hold_cnt_q;
  logic                     s2_valid_q;
  logic signed [DATA_W-1:0] s2_sample_q;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;

  logic        [15:0]       open_lvl_w;
  logic        [15:0]       close_lvl_w;
  logic        [3:0]        rel_sh_w;
  logic        [15:0]       rel_step_w;
  logic        [15:0]       hold_load_w;
  logic        [16:0]       gain_sum_w;
  logic        [15:0]       gain_up_w;
  logic signed [DATA_W+16:0] prod_w;
  logic signed [DATA_W+16:0] scaled_w;

  gate_env_follower #(
    .DATA_W    (DATA_W),
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .valid_o    (s1_valid),
    .sample_o   (s1_sample),
    .env_o      (s1_env)
  );

  // Levels derived from the live parameter bank; close level is half of open for hysteresis.
  assign open_lvl_w  = 16'(thresh_i) << 7;
  assign close_lvl_w = open_lvl_w >> 1;
  assign rel_sh_w    = (release_i > PARAM_W'(10)) ? 4'd10 : release_i[3:0];
  assign rel_step_w  = 16'd1024 >> rel_sh_w;
  assign hold_load_w = 16'(hold_i) * 16'(HOLD_UNIT);
  assign gain_sum_w  = {1'b0, gain_q} + 17'(ATTACK_STEP);
  assign gain_up_w   = (gain_sum_w >= 17'(GATE_UNITY)) ? UNITY16 : gain_sum_w[15:0];

  // Gate FSM: state, gain and hold counter advance once per S1 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      gain_q     <= '0;
      hold_cnt_q <= '0;
    end else if (s1_valid) begin
      unique case (state_q)
        CLOSED: begin
          if (s1_env > open_lvl_w) begin
            state_q <= ATTACK;
            gain_q  <= gain_up_w;
          end else begin
            gain_q <= '0;
          end
        end
        ATTACK: begin
          gain_q <= gain_up_w;
          if (gain_up_w == UNITY16) state_q <= OPEN;
        end
        OPEN: begin
          gain_q <= UNITY16;
          if (s1_env <= close_lvl_w) begin
            if (hold_i == '0) begin
              state_q <= RELEASE;
            end else begin
              state_q    <= HOLD;
              hold_cnt_q <= hold_load_w;
            end
          end
        end
        HOLD: begin
          if (s1_env > open_lvl_w) begin
            state_q <= OPEN;
          end else begin
            hold_cnt_q <= hold_cnt_q - 16'd1;
            if (hold_cnt_q == 16'd1) state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (s1_env > open_lvl_w) begin
            state_q <= ATTACK;
            gain_q  <= gain_up_w;
          end else if (gain_q <= rel_step_w) begin
            gain_q  <= '0;
            state_q <= CLOSED;
          end else begin
            gain_q <= gain_q - rel_step_w;
          end
        end
        default: state_q <= CLOSED;
      endcase
    end
  end

  // Sample pairs with the gain written on the same edge, so S3 sees the post-update gain.
  assign prod_w   = s2_sample_q * $signed({1'b0, gain_q});
  assign scaled_w = prod_w >>> 15;

  // S2/S3 pipeline: valids shift every cycle, data only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sample_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s2_valid_q  <= s1_valid;
      out_valid_q <= s2_valid_q;
      if (s1_valid) s2_sample_q <= s1_sample;
      if (s2_valid_q) out_data_q <= bypass ? s2_sample_q : sat16(scaled_w);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign gate_open = (state_q != CLOSED);

endmodule
